// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types for the tetris core and its input controller: core state/command
// encoding, button index constants and the gravity period helper.
package enum_type;

  typedef enum logic [3:0] {
    NONE       = 4'd0,
    INIT       = 4'd1,
    WAIT       = 4'd2,
    GEN        = 4'd3,
    END        = 4'd4,
    LEFT       = 4'd5,
    RIGHT      = 4'd6,
    DOWN       = 4'd7,
    DROP       = 4'd8,
    ROTATE     = 4'd9,
    ROTATE_REV = 4'd10,
    HOLD       = 4'd11
  } state_type;

  // LEFT/RIGHT/DOWN occupy indices 0..2 so the auto-repeat lanes map directly onto them.
  localparam logic [2:0] BTN_LEFT       = 3'd0;
  localparam logic [2:0] BTN_RIGHT      = 3'd1;
  localparam logic [2:0] BTN_DOWN       = 3'd2;
  localparam logic [2:0] BTN_DROP       = 3'd3;
  localparam logic [2:0] BTN_ROTATE     = 3'd4;
  localparam logic [2:0] BTN_ROTATE_REV = 3'd5;
  localparam logic [2:0] BTN_HOLD       = 3'd6;
  localparam int unsigned NUM_BTN = 7;
  localparam int unsigned NUM_RPT = 3;

  localparam logic [2:0] BTN_PRIO [NUM_BTN] = '{
    BTN_DROP, BTN_HOLD, BTN_ROTATE, BTN_ROTATE_REV, BTN_LEFT, BTN_RIGHT, BTN_DOWN
  };

  function automatic state_type btn_cmd(input logic [2:0] idx);
    case (idx)
      BTN_LEFT:       return LEFT;
      BTN_RIGHT:      return RIGHT;
      BTN_DOWN:       return DOWN;
      BTN_DROP:       return DROP;
      BTN_ROTATE:     return ROTATE;
      BTN_ROTATE_REV: return ROTATE_REV;
      BTN_HOLD:       return HOLD;
      default:        return NONE;
    endcase
  endfunction

  function automatic logic [31:0] gravity_period(input logic [3:0]  lvl,
                                                 input logic [31:0] base,
                                                 input logic [31:0] step,
                                                 input logic [31:0] floor_p);
    logic [31:0] dec;
    dec = step * {28'd0, lvl};
    if (dec >= base || (base - dec) < floor_p) return floor_p;
    return base - dec;
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Command-side bundle between the input controller and the tetris core.
interface tetris_input_ctrl_if;
  logic [enum_type::NUM_BTN-1:0] btn_raw;
  enum_type::state_type          state;
  logic [15:0]                   score;
  enum_type::state_type          ctrl;
  logic [3:0]                    level;

  modport master (output btn_raw, state, score, input ctrl, level);
  modport slave  (input btn_raw, state, score, output ctrl, level);
endinterface

// File: rtl/tetris_input_ctrl_debounce.sv
// Single-input debouncer: the level follows raw only after raw has disagreed
// with it for CYCLES consecutive clocks; any agreement restarts the count.
module btn_debounce #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) level_d = raw;
      else                          cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Upstream command stage: debounced buttons, auto-repeat and gravity become
// single-cycle commands, issued only when the core is ready to take one.
module tetris_input_ctrl
  import enum_type::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DAS_CYCLES      = 17_000_000,
  parameter int unsigned ARR_CYCLES      = 5_000_000,
  parameter int unsigned GRAVITY_BASE    = 100_000_000,
  parameter int unsigned GRAVITY_STEP    = 8_000_000,
  parameter int unsigned GRAVITY_MIN     = 10_000_000
) (
  input logic                clk,
  input logic                reset_n,
  tetris_input_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] db_lvl, db_prev_q, rise, pend_q, pend_d;
  logic [NUM_RPT-1:0] rpt_fire;
  logic [31:0]        rpt_cnt_q [NUM_RPT];
  logic [31:0]        rpt_cnt_d [NUM_RPT];
  logic [31:0]        grav_cnt_q, grav_cnt_d, grav_period;
  logic               grav_fire;
  logic [3:0]         level_q, level_d;
  state_type          ctrl_q, ctrl_d;
  logic               armed_q, armed_d;
  logic               idle_state;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (bus.btn_raw[g]),
      .level   (db_lvl[g])
    );
  end

  assign rise        = db_lvl & ~db_prev_q;
  assign idle_state  = (bus.state == INIT) || (bus.state == END);
  assign level_d     = (bus.score[15:8] != 8'd0) ? 4'd9 : bus.score[7:4];
  assign grav_period = gravity_period(level_q, 32'(GRAVITY_BASE), 32'(GRAVITY_STEP),
                                      32'(GRAVITY_MIN));

  // >= rather than == so a level-up that shrinks the period never strands the counter.
  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_fire  = 1'b0;
    if (bus.state == GEN) begin
      grav_cnt_d = '0;
    end else if (!idle_state) begin
      if (grav_cnt_q >= grav_period - 32'd1) begin
        grav_cnt_d = '0;
        grav_fire  = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 32'd1;
      end
    end
  end

  // After the first repeat the counter is rewound so later repeats land every ARR cycles.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RPT; i++) begin
      rpt_fire[i]  = 1'b0;
      rpt_cnt_d[i] = rpt_cnt_q[i] + 32'd1;
      if (!db_lvl[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (rpt_cnt_q[i] == 32'(DAS_CYCLES - 1)) begin
        rpt_fire[i]  = 1'b1;
        rpt_cnt_d[i] = 32'(DAS_CYCLES - ARR_CYCLES);
      end
    end
  end

  always_comb begin : issue
    logic       found;
    logic [2:0] win;
    pend_d                = pend_q | rise;
    pend_d[NUM_RPT-1:0]   = pend_d[NUM_RPT-1:0] | rpt_fire;
    pend_d[BTN_DOWN]      = pend_d[BTN_DOWN] | grav_fire;
    ctrl_d                = NONE;
    armed_d               = armed_q | (bus.state != WAIT);
    found                 = 1'b0;
    win                   = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      if (!found && pend_q[BTN_PRIO[k]]) begin
        found = 1'b1;
        win   = BTN_PRIO[k];
      end
    end
    if (idle_state) begin
      pend_d = '0;
      if (|rise && ctrl_q == NONE) ctrl_d = DOWN;
    end else if (armed_q && bus.state == WAIT && found) begin
      ctrl_d      = btn_cmd(win);
      pend_d[win] = 1'b0;
      armed_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_prev_q  <= '0;
      pend_q     <= '0;
      grav_cnt_q <= '0;
      level_q    <= '0;
      ctrl_q     <= NONE;
      armed_q    <= 1'b1;
      for (int unsigned i = 0; i < NUM_RPT; i++) rpt_cnt_q[i] <= '0;
    end else begin
      db_prev_q  <= db_lvl;
      pend_q     <= pend_d;
      grav_cnt_q <= grav_cnt_d;
      level_q    <= level_d;
      ctrl_q     <= ctrl_d;
      armed_q    <= armed_d;
      for (int unsigned i = 0; i < NUM_RPT; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

  assign bus.ctrl  = ctrl_q;
  assign bus.level = level_q;

endmodule
